// File: rtl/fifo_buffer.sv
// Single-clock FIFO, 2**DEPTH_BITS x DATA_WIDTH; FIFO_ERR_FLAGS_EN adds overflow/underflow pulses.
// Latency: registered read, word appears on rd_data one edge after an accepted rd_en.
// Backpressure: writes dropped while full, reads ignored while empty (rd_data holds).
module fifo_buffer #(
  parameter int DEPTH_BITS = 3,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic                  empty
`endif
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic [DEPTH_BITS:0]   count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance uses the registered flags, so simultaneous requests see pre-edge state.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage is never reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: vector table for reset/fill/drain, queue scoreboard for every edge.
module tb_fifo_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       full;
  logic       empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  fifo_buffer #(.DEPTH_BITS(3), .DATA_WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .full     (full),
`ifdef FIFO_ERR_FLAGS_EN
    .empty    (empty),
    .overflow (overflow),
    .underflow(underflow)
`else
    .empty    (empty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [3:0] wd;
    logic       re;
    logic       full;
    logic       empty;
    logic [3:0] rd;
    logic       ovf;
    logic       unf;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  int total = 0;
  int bad   = 0;

  logic [3:0] sb [$];
  logic [3:0] m_rd;
  logic       m_ovf;
  logic       m_unf;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Drive one edge, update the reference queue from pre-edge state, then compare.
  task automatic step(input logic r, input logic w, input logic [3:0] d, input logic rr);
    bit mf;
    bit me;
    reset   = r;
    wr_en   = w;
    wr_data = d;
    rd_en   = rr;
    mf = (sb.size() == 8);
    me = (sb.size() == 0);
    if (r) begin
      sb.delete();
      m_rd  = 4'h0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = w && mf;
      m_unf = rr && me;
      if (rr && !me) m_rd = sb.pop_front();
      if (w && !mf) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    check("sb_rd_data", {4'h0, rd_data}, {4'h0, m_rd});
    check("sb_full", {7'h0, full}, {7'h0, sb.size() == 8});
    check("sb_empty", {7'h0, empty}, {7'h0, sb.size() == 0});
`ifdef FIFO_ERR_FLAGS_EN
    check("sb_overflow", {7'h0, overflow}, {7'h0, m_ovf});
    check("sb_underflow", {7'h0, underflow}, {7'h0, m_unf});
`endif
  endtask

  initial begin
    // Reset x2, fill 0..7, write 8 while full, then 10 reads.
    for (int i = 0; i < 2; i++)
      vecs[i] = '{rst:1'b1, we:1'b0, wd:4'h0, re:1'b0, full:1'b0, empty:1'b1, rd:4'h0, ovf:1'b0, unf:1'b0};
    for (int i = 0; i < 8; i++)
      vecs[2+i] = '{rst:1'b0, we:1'b1, wd:4'(i), re:1'b0, full:(i == 7), empty:1'b0, rd:4'h0, ovf:1'b0, unf:1'b0};
    vecs[10] = '{rst:1'b0, we:1'b1, wd:4'h8, re:1'b0, full:1'b1, empty:1'b0, rd:4'h0, ovf:1'b1, unf:1'b0};
    for (int k = 0; k < 10; k++)
      vecs[11+k] = '{rst:1'b0, we:1'b0, wd:4'h0, re:1'b1, full:1'b0, empty:(k >= 7),
                     rd:(k > 7) ? 4'h7 : 4'(k), ovf:1'b0, unf:(k >= 8)};

    reset = 1'b1; wr_en = 1'b0; wr_data = 4'h0; rd_en = 1'b0;
    m_rd = 4'h0; m_ovf = 1'b0; m_unf = 1'b0;
    #2;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re);
      check($sformatf("vec%0d_rd_data", i), {4'h0, rd_data}, {4'h0, vecs[i].rd});
      check($sformatf("vec%0d_full", i), {7'h0, full}, {7'h0, vecs[i].full});
      check($sformatf("vec%0d_empty", i), {7'h0, empty}, {7'h0, vecs[i].empty});
`ifdef FIFO_ERR_FLAGS_EN
      check($sformatf("vec%0d_overflow", i), {7'h0, overflow}, {7'h0, vecs[i].ovf});
      check($sformatf("vec%0d_underflow", i), {7'h0, underflow}, {7'h0, vecs[i].unf});
`endif
    end

    // Wrap-around: 5 in/out moves the pointers off zero, then a full 8-word pass.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'(i + 3), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 1'b1);
    check("wrap_rd5", {4'h0, rd_data}, 8'h07);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'(4'hA + i), 1'b0);
    check("wrap_full", {7'h0, full}, 8'h01);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 4'h0, 1'b1);
    check("wrap_last", {4'h0, rd_data}, 8'h01);
    check("wrap_empty", {7'h0, empty}, 8'h01);

    // Simultaneous read+write with 3 held: occupancy steady, oldest word out.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'(i + 2), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'(i + 5), 1'b1);
      check($sformatf("simul_rd%0d", i), {4'h0, rd_data}, {4'h0, 4'(i + 2)});
    end
    check("simul_count", sb.size(), 8'd3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'(4'hB + i), 1'b0);
    check("simul_full", {7'h0, full}, 8'h01);
    step(1'b0, 1'b1, 4'hE, 1'b1);
    check("full_both_rd", {4'h0, rd_data}, 8'h06);
    check("full_both_clear", {7'h0, full}, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'h0, 1'b1);
    check("drain_empty", {7'h0, empty}, 8'h01);
    step(1'b0, 1'b1, 4'hC, 1'b1);
    check("empty_both_hold", {4'h0, rd_data}, 8'h0F);
    check("empty_both_clear", {7'h0, empty}, 8'h00);

    // Mid-operation reset with 4 words held.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'(i + 1), 1'b0);
    check("pre_rst_count", sb.size(), 8'd4);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    check("mrst_empty", {7'h0, empty}, 8'h01);
    check("mrst_full", {7'h0, full}, 8'h00);
    check("mrst_rd_data", {4'h0, rd_data}, 8'h00);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'h0, 1'b1);
    check("mrst_rd_ignored", {4'h0, rd_data}, 8'h00);
    step(1'b0, 1'b1, 4'h9, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("mrst_new_word", {4'h0, rd_data}, 8'h09);
    check("mrst_end_empty", {7'h0, empty}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
Synchronous single-clock FIFO with parameterised data width and power-of-two depth.
- Stores words written with wr_en and returns them in order via a registered read port.
- Exposes full and empty status flags.
- Used as a generic elastic buffer between producer and consumer logic in the same clock domain.

Parameters:
- DEPTH_BITS, 3, log2 of FIFO depth; capacity = 2**DEPTH_BITS words (default 8).
- DATA_WIDTH, 4, width of each stored word in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  word to write.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  registered read data.
- full  output  1  FIFO holds 2**DEPTH_BITS words.
- empty  output  1  FIFO holds 0 words.

Behaviour:
- Reset (reset=1 at a rising edge):
  - write pointer, read pointer and count cleared to 0.
  - full=0, empty=1, rd_data=0.
  - Memory contents are not cleared.
  - Reset has priority over all other inputs, including mid-operation; any data held is discarded.
- Write: at a rising edge with wr_en=1 and full=0, wr_data is stored at the write pointer, and the write pointer increments modulo 2**DEPTH_BITS.
- A write with full=1 is ignored: no storage change, no pointer change.
- Read: at a rising edge with rd_en=1 and empty=0, rd_data loads the word at the read pointer, and the read pointer increments modulo 2**DEPTH_BITS.
  - Latency is 1 cycle: data is visible on rd_data after the sampling edge.
- A read with empty=1 is ignored, and rd_data holds its previous value.
- rd_data holds its value in every cycle without an accepted read.
- Simultaneous wr_en and rd_en:
  - each is accepted independently using the flags as they stood before the edge.
  - if neither is blocked, occupancy is unchanged.
  - when full=1, only the read is accepted; when empty=1, only the write is accepted.
- Occupancy count, DEPTH_BITS+1 bits wide:
  - +1 on write only, −1 on read only, unchanged otherwise.
  - Never exceeds 2**DEPTH_BITS and never underflows.
- Flags are registered and reflect occupancy after the edge:
  - full=1 exactly when count==2**DEPTH_BITS.
  - empty=1 exactly when count==0.
- Pointer wrap-around is seamless; ordering is preserved across any number of wraps.
- Memory is inferred as a register array of 2**DEPTH_BITS × DATA_WIDTH.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- Defined: two extra 1-bit outputs are added after empty.
  - overflow: registered, 1 for exactly one cycle after an edge where wr_en=1 and full=1 and no write was accepted.
  - underflow: registered, 1 for exactly one cycle after an edge where rd_en=1 and empty=1.
  - Both are cleared to 0 by reset.
- Not defined: these ports and their logic are absent; the port list is exactly as listed above.

Test Plan:
- Reset check: hold reset=1 for 2 edges -> empty=1, full=0, rd_data=0.
- Fill:
  - Stimulus: release reset, then write 0,1,…,7 on consecutive edges (DEPTH_BITS=3, DATA_WIDTH=4).
  - Response: empty drops after the first write; full=1 after the 8th write.
  - Then write 8 with full=1 -> ignored; full stays 1; overflow pulses if FIFO_ERR_FLAGS_EN is defined.
- Drain:
  - Stimulus: wr_en=0, rd_en=1 for 10 edges.
  - Response: rd_data = 0,1,…,7 on successive cycles; full clears after the first read; empty=1 after the 8th read.
  - The two extra reads leave rd_data=7; underflow pulses if enabled.
- Wrap-around:
  - Stimulus: write 5 words, read 5, then write 0xA–0xF plus 0x0,0x1 (8 words), then read 8.
  - Response: data returned in write order; full then empty sequence correct.
- Simultaneous:
  - Stimulus: with 3 words held, wr_en=rd_en=1 for 4 edges -> count stays 3 and the oldest word is output each cycle.
  - Stimulus: when full, both asserted -> read only, full clears.
  - Stimulus: when empty, both asserted -> write only, empty clears.
- Mid-operation reset: with 4 words held, pulse reset for 1 edge -> empty=1, full=0, rd_data=0; subsequent reads are ignored until new data is written.
